// File: rtl/idct_toplayici.sv
// idct_toplayici -- IDCT term accumulator, pixel converter and output FIFO.
//
// Sums TERIM_SAYISI consecutive signed Q-format product terms into one
// spatial sample, converts it to an 8-bit pixel (arithmetic shift by Q_FRAC,
// +128 level shift, saturation to [0,255]) and queues the pixel with its
// block index in a first-word-fall-through FIFO.
//
// Optional feature macro: IDCT_YUVARLA_EN
//   defined   -> round half up before the shift
//   undefined -> truncating arithmetic shift (toward -inf)
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   islem_veri_i         signed Q term from upstream
//   islem_index_i        pixel index of the term
//   islem_gecerli_i      term valid (no backpressure upstream)
//   sonuc_veri_o         unsigned pixel at FIFO head
//   sonuc_index_o        pixel index at FIFO head
//   sonuc_gecerli_o      FIFO not empty
//   sonuc_hazir_i        consumer ready
//   tasma_o              sticky: pixel dropped on a full FIFO
//   index_hata_o         sticky: index changed inside a group

`ifndef Q_BIT
`define Q_BIT 32
`endif
`ifndef BLOCK_AREA_BIT
`define BLOCK_AREA_BIT 6
`endif

module idct_toplayici #(
    parameter int TERIM_SAYISI  = 64,
    parameter int ACC_EK_BIT    = 6,
    parameter int Q_FRAC        = 16,
    parameter int FIFO_DERINLIK = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [`Q_BIT-1:0]          islem_veri_i,
    input  logic [`BLOCK_AREA_BIT-1:0] islem_index_i,
    input  logic                       islem_gecerli_i,
    output logic [7:0]                 sonuc_veri_o,
    output logic [`BLOCK_AREA_BIT-1:0] sonuc_index_o,
    output logic                       sonuc_gecerli_o,
    input  logic                       sonuc_hazir_i,
    output logic                       tasma_o,
    output logic                       index_hata_o
);
    localparam int QB    = `Q_BIT;
    localparam int IB    = `BLOCK_AREA_BIT;
    localparam int ACC_W = QB + ACC_EK_BIT;
    localparam int CW    = $clog2(TERIM_SAYISI);
    localparam int PW    = $clog2(FIFO_DERINLIK);
    localparam logic [CW-1:0] SON_TERIM = CW'(TERIM_SAYISI - 1);
    localparam logic [PW:0]   DOLU      = (PW+1)'(FIFO_DERINLIK);

    typedef struct packed {
        logic [7:0]    veri;
        logic [IB-1:0] idx;
    } giris_t;

    // ---------------- accumulate ----------------
    logic [CW-1:0]           r_sayac;
    logic signed [ACC_W-1:0] r_acc;
    logic [IB-1:0]           r_grp_idx;
    logic signed [ACC_W-1:0] w_terim;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [IB-1:0]           w_grp_idx;

    assign w_terim    = {{ACC_EK_BIT{islem_veri_i[QB-1]}}, islem_veri_i};
    assign w_acc_next = (r_sayac == '0) ? w_terim : r_acc + w_terim;
    // First term of a group supplies the index for that same cycle.
    assign w_grp_idx  = (r_sayac == '0) ? islem_index_i : r_grp_idx;

    // ---------------- conversion stage ----------------
    logic signed [ACC_W-1:0] r_don_sum;
    logic [IB-1:0]           r_don_idx;
    logic                    r_don_gecerli;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_tam;
    logic signed [ACC_W:0]   w_p;
    logic [7:0]              w_pix;

`ifdef IDCT_YUVARLA_EN
    localparam logic signed [ACC_W:0] YARIM = (ACC_W+1)'(1) << (Q_FRAC - 1);
    assign w_rnd = {r_don_sum[ACC_W-1], r_don_sum} + YARIM;
`else
    assign w_rnd = {r_don_sum[ACC_W-1], r_don_sum};
`endif
    assign w_tam = w_rnd >>> Q_FRAC;
    assign w_p   = w_tam + (ACC_W+1)'(128);

    always_comb begin
        w_pix = w_p[7:0];
        if (w_p[ACC_W])            w_pix = 8'd0;    // negative
        else if (|w_p[ACC_W-1:8])  w_pix = 8'd255;  // above 255
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sayac       <= '0;
            r_acc         <= '0;
            r_grp_idx     <= '0;
            r_don_sum     <= '0;
            r_don_idx     <= '0;
            r_don_gecerli <= 1'b0;
            index_hata_o  <= 1'b0;
        end else begin
            r_don_gecerli <= 1'b0;
            if (islem_gecerli_i) begin
                r_acc     <= w_acc_next;
                r_grp_idx <= w_grp_idx;
                r_sayac   <= (r_sayac == SON_TERIM) ? '0 : r_sayac + 1'b1;
                if (r_sayac != '0 && islem_index_i != r_grp_idx)
                    index_hata_o <= 1'b1;
                if (r_sayac == SON_TERIM) begin
                    r_don_sum     <= w_acc_next;
                    r_don_idx     <= w_grp_idx;
                    r_don_gecerli <= 1'b1;
                end
            end
        end
    end

    // ---------------- output FIFO ----------------
    giris_t        r_mem [FIFO_DERINLIK];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_cnt;
    logic          w_pop, w_push, w_dolu, w_yaz;

    assign w_pop  = sonuc_gecerli_o && sonuc_hazir_i;
    assign w_push = r_don_gecerli;
    assign w_dolu = (r_cnt == DOLU);
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_yaz  = w_push && (!w_dolu || w_pop);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DERINLIK; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            tasma_o <= 1'b0;
        end else begin
            if (w_yaz) begin
                r_mem[r_wptr] <= '{veri: w_pix, idx: r_don_idx};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_push && !w_yaz) tasma_o <= 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_yaz && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_yaz && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign sonuc_gecerli_o = (r_cnt != '0);
    assign sonuc_veri_o    = r_mem[r_rptr].veri;
    assign sonuc_index_o   = r_mem[r_rptr].idx;

endmodule

// File: tb/tb_idct_toplayici.sv
module tb_idct_toplayici;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] veri;
    logic [5:0]  idx;
    logic        gec;
    logic [7:0]  o_veri;
    logic [5:0]  o_idx;
    logic        o_gec;
    logic        hazir;
    logic        tasma, hata;

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] pix_q[$];   // {pixel, index} of every pop

    idct_toplayici dut (
        .clk_i(clk), .rstn_i(rstn),
        .islem_veri_i(veri), .islem_index_i(idx), .islem_gecerli_i(gec),
        .sonuc_veri_o(o_veri), .sonuc_index_o(o_idx), .sonuc_gecerli_o(o_gec),
        .sonuc_hazir_i(hazir), .tasma_o(tasma), .index_hata_o(hata)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; pops are observed at negedge.
    always @(negedge clk)
        if (rstn && o_gec && hazir) pix_q.push_back({o_veri, o_idx});

    typedef struct {
        logic [31:0] term;
        logic [5:0]  ix;
        logic [7:0]  pix;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic term(input logic [31:0] v, input logic [5:0] ix);
        @(posedge clk); #1;
        veri = v; idx = ix; gec = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            gec = 1'b0;
        end
    endtask

    task automatic grp(input logic [31:0] v, input logic [5:0] ix);
        for (int i = 0; i < 64; i++) term(v, ix);
        idle(1);
    endtask

    task automatic wait_pix(input int n, input string nm);
        int t;
        t = 0;
        while (pix_q.size() < n && t < 40) begin
            @(negedge clk); t++;
        end
        chk({nm, "_timeout"}, 32'(pix_q.size() >= n), 32'd1);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{32'h0001_0000, 6'd1, 8'd192};
        tbl[1] = '{32'hFFFF_0000, 6'd2, 8'd64};
        tbl[2] = '{32'h0004_0000, 6'd3, 8'd255};
        tbl[3] = '{32'hFFFC_0000, 6'd4, 8'd0};
        tbl[4] = '{32'h0000_8000, 6'd10, 8'd160};
        tbl[5] = '{32'hFFFF_C000, 6'd20, 8'd112};
        tbl[6] = '{32'h0001_FC00, 6'd30, 8'd255};  // sum 127 -> exactly 255
        tbl[7] = '{32'hFFFE_0000, 6'd40, 8'd0};    // sum -128 -> exactly 0
        tbl[8] = '{32'h0000_0001, 6'd50, 8'd128};
`ifdef IDCT_YUVARLA_EN
        tbl[9] = '{32'hFFFF_FFFF, 6'd63, 8'd128};
`else
        tbl[9] = '{32'hFFFF_FFFF, 6'd63, 8'd127};  // -64/65536 floors to -1
`endif

        rstn = 1'b0; veri = '0; idx = '0; gec = 1'b0; hazir = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gec", 32'(o_gec), 0);
        chk("rst_veri", 32'(o_veri), 0);
        chk("rst_tasma", 32'(tasma), 0);
        chk("rst_hata", 32'(hata), 0);
        @(posedge clk); #1; rstn = 1'b1;

        // latency: one valid cycle, two edges after the last term
        for (int i = 0; i < 64; i++) term(32'h0001_0000, 6'd5);
        idle(1);
        @(negedge clk); chk("lat_k", 32'(o_gec), 0);
        @(negedge clk);
        chk("lat_k1_gec", 32'(o_gec), 1);
        chk("lat_k1_veri", 32'(o_veri), 192);
        chk("lat_k1_idx", 32'(o_idx), 5);
        @(negedge clk); chk("lat_k2_gec", 32'(o_gec), 0);
        pix_q.delete();

        // table of full groups
        for (int v = 0; v < 10; v++) begin
            grp(tbl[v].term, tbl[v].ix);
            wait_pix(1, "tbl");
            if (pix_q.size() > 0) begin
                chk($sformatf("tbl%0d_pix", v), 32'(pix_q[0][13:6]), 32'(tbl[v].pix));
                chk($sformatf("tbl%0d_idx", v), 32'(pix_q[0][5:0]), 32'(tbl[v].ix));
            end
            pix_q.delete();
        end

        // rounding with gaps
        term(32'h0000_8000, 6'd3);
        for (int i = 0; i < 63; i++) begin
            idle($urandom_range(0, 2));
            term(32'h0, 6'd3);
        end
        idle(1);
        wait_pix(1, "rnd");
`ifdef IDCT_YUVARLA_EN
        if (pix_q.size() > 0) chk("rnd_pix", 32'(pix_q[0][13:6]), 129);
`else
        if (pix_q.size() > 0) chk("rnd_pix", 32'(pix_q[0][13:6]), 128);
`endif
        pix_q.delete();

        // overflow: 5 groups into a 4-entry FIFO
        hazir = 1'b0;
        for (int g = 0; g < 5; g++) grp(32'h0001_0000, 6'(g));
        idle(3);
        chk("ovf_tasma", 32'(tasma), 1);
        chk("ovf_head", 32'(o_idx), 0);
        @(posedge clk); #1; hazir = 1'b1;
        wait_pix(4, "ovf");
        for (int i = 0; i < 4 && i < pix_q.size(); i++)
            chk($sformatf("ovf_pop%0d", i), 32'(pix_q[i][5:0]), i);
        idle(2);
        chk("ovf_empty", 32'(o_gec), 0);
        chk("ovf_cnt", 32'(pix_q.size()), 4);
        pix_q.delete();

        // reset mid-group, with a pixel queued and tasma set
        hazir = 1'b0;
        grp(32'h0001_0000, 6'd9);
        idle(2);
        chk("prer_gec", 32'(o_gec), 1);
        for (int i = 0; i < 30; i++) term(32'h0001_0000, 6'd11);
        @(posedge clk); #1; rstn = 1'b0; gec = 1'b0;
        @(negedge clk);
        chk("mr_gec", 32'(o_gec), 0);
        chk("mr_veri", 32'(o_veri), 0);
        chk("mr_idx", 32'(o_idx), 0);
        chk("mr_tasma", 32'(tasma), 0);
        chk("mr_hata", 32'(hata), 0);
        @(posedge clk); #1; rstn = 1'b1; hazir = 1'b1;
        pix_q.delete();
        grp(32'h0001_0000, 6'd2);
        idle(6);
        chk("mr_npix", 32'(pix_q.size()), 1);
        if (pix_q.size() > 0) begin
            chk("mr_pix", 32'(pix_q[0][13:6]), 192);
            chk("mr_pidx", 32'(pix_q[0][5:0]), 2);
        end
        pix_q.delete();

        // full FIFO with push and pop in the same cycle
        hazir = 1'b0;
        for (int g = 0; g < 4; g++) grp(32'h0001_0000, 6'(g));
        idle(3);
        chk("pp_pre_tasma", 32'(tasma), 0);
        for (int i = 0; i < 64; i++) term(32'h0001_0000, 6'd4);
        @(posedge clk); #1; gec = 1'b0; hazir = 1'b1;  // pop on the push edge
        @(posedge clk); #1; hazir = 1'b0;
        idle(2);
        chk("pp_tasma", 32'(tasma), 0);
        chk("pp_one", 32'(pix_q.size()), 1);
        hazir = 1'b1;
        wait_pix(5, "pp");
        for (int i = 0; i < 5 && i < pix_q.size(); i++)
            chk($sformatf("pp_pop%0d", i), 32'(pix_q[i][5:0]), i);
        pix_q.delete();

        // index error inside a group
        chk("ie_pre", 32'(hata), 0);
        for (int i = 0; i < 64; i++) term(32'h0001_0000, (i == 19) ? 6'd8 : 6'd7);
        idle(4);
        chk("ie_flag", 32'(hata), 1);
        wait_pix(1, "ie");
        if (pix_q.size() > 0) begin
            chk("ie_pix", 32'(pix_q[0][13:6]), 192);
            chk("ie_idx", 32'(pix_q[0][5:0]), 7);
        end
        idle(5);
        chk("ie_sticky", 32'(hata), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/idct_toplayici.md
Name: idct_toplayici

Overview:
- Downstream neighbour of the IDCT term-product pipeline: consumes the stream of scaled product terms (matrix x cos x cos x alpha x alpha) and sums TERIM_SAYISI consecutive terms into one spatial pixel.
- Converts each Q-format sum to an 8-bit pixel: arithmetic shift, +128 level shift, saturation.
- Buffers pixels in a small output FIFO with valid/ready toward the block writer.
- No input backpressure, because the upstream pipeline is fixed-latency.

Parameters:
- TERIM_SAYISI, 64, terms summed per output pixel (power of two)
- ACC_EK_BIT, 6, accumulator guard bits beyond `Q_BIT (log2 TERIM_SAYISI)
- Q_FRAC, 16, fractional bits of the `Q_BIT input format
- FIFO_DERINLIK, 4, output FIFO entries (power of two, >=2)

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  asynchronous active-low reset
- islem_veri_i  input  `Q_BIT  signed Q term from upstream
- islem_index_i  input  `BLOCK_AREA_BIT  pixel index of the term
- islem_gecerli_i  input  1  term valid
- sonuc_veri_o  output  8  unsigned pixel, FIFO head
- sonuc_index_o  output  `BLOCK_AREA_BIT  pixel index, FIFO head
- sonuc_gecerli_o  output  1  FIFO not empty
- sonuc_hazir_i  input  1  consumer ready
- tasma_o  output  1  sticky: result dropped because FIFO full
- index_hata_o  output  1  sticky: index changed inside a group

Behaviour:
- Clock and reset (already decided): one clock clk_i; reset rstn_i is asynchronous, active-low.
- Reset clears all state:
  - counter, accumulator, conversion stage and FIFO pointers/count go to 0.
  - sonuc_gecerli_o=0, sonuc_veri_o=0, sonuc_index_o=0, tasma_o=0, index_hata_o=0.
  - Reset mid-group discards the partial sum; the next valid term starts a new group.
- Accumulate (valid term only; gaps with islem_gecerli_i=0 hold all state):
  - Accumulator is signed, `Q_BIT+ACC_EK_BIT wide.
  - Input term is sign-extended.
  - When sayac==0: acc<=term and the group index is captured. Otherwise acc<=acc+term.
  - sayac increments and wraps to 0 after the TERIM_SAYISI-1 term.
  - Accumulator never overflows at these widths; no internal saturation.
- Index check: a term with sayac!=0 whose index differs from the captured group index sets index_hata_o. The sum still proceeds and the captured index is used.
- Group close: on the final term (sayac==TERIM_SAYISI-1), acc+term is computed combinationally and registered into the conversion stage with the group index; donustur_gecerli=1.
- Conversion (combinational from the conversion-stage register):
  - tam = sum >>> Q_FRAC (arithmetic; truncation toward -inf).
  - p = tam + 128.
  - Saturate p to [0,255].
- Push: the next cycle, the converted pixel and index are written to the FIFO.
- Latency: final term sampled at edge k -> sonuc_gecerli_o=1 after edge k+1 if the FIFO was empty. Back-to-back groups yield one pixel per TERIM_SAYISI valid cycles.
- FIFO:
  - First-word-fall-through; outputs reflect the head entry.
  - Pop when sonuc_gecerli_o && sonuc_hazir_i.
  - Push and pop in the same cycle are both performed; count unchanged, including when full.
  - Push while full with no pop: the result is dropped, FIFO contents unchanged, tasma_o<=1.
  - Pop while empty is impossible, since valid=0.
  - Pointers wrap modulo FIFO_DERINLIK.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: IDCT_YUVARLA_EN.
- Defined: round half up. Before the shift, sum += 1<<(Q_FRAC-1), i.e. tam = (sum + 2^(Q_FRAC-1)) >>> Q_FRAC, then level shift and saturation as above.
- Undefined: plain truncating arithmetic shift.
- Latency is identical in both cases.

Test Plan:
- 64 terms 0x00010000 (1.0), index 5, consecutive, sonuc_hazir_i=1 -> two edges after the last term: sonuc_veri_o=192, sonuc_index_o=5, one cycle valid.
- 64 terms 0xFFFF0000 (-1.0), then 64 terms 0x00040000 (4.0), then 64 terms 0xFFFC0000 (-4.0) -> pixels 64, 255 (saturated), 0 (saturated) in order.
- One term 0x00008000 plus 63 zero terms, with random gecerli gaps -> 128 without IDCT_YUVARLA_EN, 129 with it. Gaps do not change the result.
- sonuc_hazir_i=0, 5 full groups with indices 0..4 -> after the 5th close: tasma_o=1, FIFO holds 0..3. Raise hazir -> pops indices 0,1,2,3, then valid=0. Separately: FIFO full with pop and push in the same cycle -> no drop, tasma_o stays 0.
- 30 terms of 1.0, assert rstn_i for 1 cycle mid-group, then 64 terms of 1.0 -> exactly one pixel 192; all outputs 0 during reset.
- Group index 7 with term 20 carrying index 8 -> index_hata_o=1 (sticky), pixel still emitted with index 7.
